// File: rtl/signal_measure.sv
// Windowed sample-stream analyser: per-window max/min/peak-to-peak and a
// hysteresis-based rising mid-level crossing count, after one calibration window.
module signal_measure #(
  parameter int WINDOW = 1024,
  parameter int HYST   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  output logic [11:0] peak_max,
  output logic [11:0] peak_min,
  output logic [11:0] vpp,
  output logic [15:0] cross_cnt,
  output logic        meas_valid
);

  localparam int CW = $clog2(WINDOW);
  localparam logic [CW-1:0] LAST_IDX = CW'(WINDOW - 1);

  typedef enum logic [0:0] {
    ST_CAL  = 1'b0,
    ST_MEAS = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  win_cnt_q, win_cnt_d;
  logic [11:0]    run_max_q, run_max_d;
  logic [11:0]    run_min_q, run_min_d;
  logic [11:0]    thr_q, thr_d;
  logic           armed_q, armed_d;
  logic [15:0]    cross_q, cross_d;
  logic [11:0]    peak_max_q, peak_max_d;
  logic [11:0]    peak_min_q, peak_min_d;
  logic [11:0]    vpp_q, vpp_d;
  logic [15:0]    cross_cnt_q, cross_cnt_d;
  logic           meas_valid_q, meas_valid_d;

  logic               first_s, last_s, rise_s;
  logic [11:0]        max_upd_s, min_upd_s, thr_s, lo_s, hi_s;
  logic [12:0]        sum_s;
  logic signed [13:0] lo_raw_s, hi_raw_s;
  logic [15:0]        base_s, cnt_upd_s;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      return v;
    end else begin
      return v + 16'd1;
    end
  endfunction

  // Hysteresis band around the latched threshold, clamped to the sample range.
  always_comb begin
    lo_raw_s = $signed({2'b00, thr_q}) - $signed(14'(HYST));
    hi_raw_s = $signed({2'b00, thr_q}) + $signed(14'(HYST));
    if (lo_raw_s < 14'sd0) begin
      lo_s = 12'd0;
    end else begin
      lo_s = lo_raw_s[11:0];
    end
    if (hi_raw_s > 14'sd4095) begin
      hi_s = 12'd4095;
    end else begin
      hi_s = hi_raw_s[11:0];
    end
  end

  // Running extremes and crossing count including the sample being accepted now.
  always_comb begin
    first_s = (win_cnt_q == '0);
    last_s  = (win_cnt_q == LAST_IDX);
    if (first_s || (sample_in > run_max_q)) begin
      max_upd_s = sample_in;
    end else begin
      max_upd_s = run_max_q;
    end
    if (first_s || (sample_in < run_min_q)) begin
      min_upd_s = sample_in;
    end else begin
      min_upd_s = run_min_q;
    end
    sum_s  = {1'b0, max_upd_s} + {1'b0, min_upd_s};
    thr_s  = 12'(sum_s >> 13'd1);
    rise_s = armed_q && (sample_in >= hi_s);
    base_s = first_s ? 16'd0 : cross_q;
    if ((state_q == ST_MEAS) && rise_s) begin
      cnt_upd_s = sat_inc(base_s);
    end else begin
      cnt_upd_s = base_s;
    end
  end

  // Next-state logic: everything advances only on accepted samples.
  always_comb begin
    state_d      = state_q;
    win_cnt_d    = win_cnt_q;
    run_max_d    = run_max_q;
    run_min_d    = run_min_q;
    thr_d        = thr_q;
    armed_d      = armed_q;
    cross_d      = cross_q;
    peak_max_d   = peak_max_q;
    peak_min_d   = peak_min_q;
    vpp_d        = vpp_q;
    cross_cnt_d  = cross_cnt_q;
    meas_valid_d = 1'b0;
    if (sample_valid) begin
      win_cnt_d = last_s ? '0 : (win_cnt_q + CW'(1));
      run_max_d = max_upd_s;
      run_min_d = min_upd_s;
      cross_d   = cnt_upd_s;
      if (rise_s) begin
        armed_d = 1'b0;
      end else if (sample_in < lo_s) begin
        armed_d = 1'b1;
      end else begin
        armed_d = armed_q;
      end
      if (last_s) begin
        thr_d = thr_s;
        case (state_q)
          ST_CAL: begin
            state_d = ST_MEAS;
          end
          ST_MEAS: begin
            peak_max_d   = max_upd_s;
            peak_min_d   = min_upd_s;
            vpp_d        = max_upd_s - min_upd_s;
            cross_cnt_d  = cnt_upd_s;
            meas_valid_d = 1'b1;
          end
          default: begin
            state_d = ST_CAL;
          end
        endcase
      end else begin
        thr_d = thr_q;
      end
    end else begin
      win_cnt_d = win_cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_CAL;
      win_cnt_q    <= '0;
      run_max_q    <= 12'd0;
      run_min_q    <= 12'd0;
      thr_q        <= 12'd0;
      armed_q      <= 1'b0;
      cross_q      <= 16'd0;
      peak_max_q   <= 12'd0;
      peak_min_q   <= 12'd0;
      vpp_q        <= 12'd0;
      cross_cnt_q  <= 16'd0;
      meas_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_cnt_q    <= win_cnt_d;
      run_max_q    <= run_max_d;
      run_min_q    <= run_min_d;
      thr_q        <= thr_d;
      armed_q      <= armed_d;
      cross_q      <= cross_d;
      peak_max_q   <= peak_max_d;
      peak_min_q   <= peak_min_d;
      vpp_q        <= vpp_d;
      cross_cnt_q  <= cross_cnt_d;
      meas_valid_q <= meas_valid_d;
    end
  end

  assign peak_max   = peak_max_q;
  assign peak_min   = peak_min_q;
  assign vpp        = vpp_q;
  assign cross_cnt  = cross_cnt_q;
  assign meas_valid = meas_valid_q;

endmodule

// File: doc/signal_measure.md
# signal_measure

Sample-stream analyser that sits on the receiving end of the 12-bit wave sample bus (`wave_out`) driven by the signal generator. It measures amplitude and frequency so the generator's settings can be checked in loopback or on captured ADC data. Each fixed-length window yields maximum, minimum, peak-to-peak value and a count of rising mid-level crossings. The crossing detector uses hysteresis, so crossings / WINDOW × sample rate gives the signal frequency.

## Interface
- `WINDOW`, 1024: number of accepted samples per measurement window; must be ≥ 2.
- `HYST`, 64: hysteresis half-width in sample LSBs, applied around the mid-level threshold.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `sample_in` input 12: unsigned sample, 0–4095.
- `sample_valid` input 1: `sample_in` is accepted on a rising edge where this is high; may be held high or gapped arbitrarily.
- `peak_max` output 12: largest sample of the last completed measure window.
- `peak_min` output 12: smallest sample of the last completed measure window.
- `vpp` output 12: `peak_max` − `peak_min` of the last completed window.
- `cross_cnt` output 16: rising crossings counted in the last completed window; saturates at 65535.
- `meas_valid` output 1: one-cycle pulse when the outputs above update.

## Operation
- **Window counter**
  - 0..WINDOW-1; increments only on accepted samples.
  - The accepted sample at index WINDOW-1 is the last sample of the window. The counter then wraps to 0.
- **Running max/min**
  - The first accepted sample of every window loads both `run_max` and `run_min`.
  - Each later accepted sample updates them with an unsigned compare.
- **Threshold**
  - `thr` = (`run_max` + `run_min`) >> 1, with a 13-bit sum and truncation.
  - Latched at the end of each window; used throughout the following window.
  - `lo` = max(`thr` − HYST, 0) and `hi` = min(`thr` + HYST, 4095), each computed in 14-bit signed arithmetic and then clamped.
- **Crossing detector**
  - Holds an `armed` flag.
  - On an accepted sample < `lo`, `armed` is set.
  - On an accepted sample ≥ `hi` while `armed` is set, the crossing counter increments (saturating at 65535) and `armed` is cleared.
  - `armed` persists across window boundaries. The crossing counter clears at window start.
  - A crossing on the last sample of a window counts in that window.
- **State machine**
  - **CAL**: entered at reset. Collects max/min for one window. Crossings are not counted and outputs are not updated. At window end it latches `thr` and goes to MEAS.
  - **MEAS**: counts crossings with the latched `thr`. At window end it:
    - copies max, min, vpp and count to the outputs;
    - pulses `meas_valid`;
    - latches a new `thr` from this window's max/min;
    - stays in MEAS.
- **Flat input**: if `vpp` ≤ 2×HYST, crossings are still evaluated with the clamped `lo`/`hi`. No special case exists; a flat signal naturally yields 0.
- **Reset**
  - All outputs go to 0, `meas_valid` to 0, state to CAL.
  - Counters, `armed` and `thr` are cleared.
  - Reset mid-window discards the partial window. The next `meas_valid` pulse comes only after a full CAL window plus a full MEAS window.

## Timing
- Every register updates on the rising edge of the accepting clock. No combinational path runs from `sample_in` to any output.
- End-of-window outputs and the `meas_valid` pulse are visible in the cycle immediately after the edge that accepted sample WINDOW-1.
  - `meas_valid` is high for exactly one cycle, even if `sample_valid` stays high.
  - Outputs hold their values until the next window end.
- The first `meas_valid` pulse comes 2×WINDOW accepted samples after reset release.
- With continuous `sample_valid`, pulses repeat every WINDOW cycles.
- `sample_valid` low cycles stall all counters and state, with no other effect.
- A crossing decision uses only the current sample and `armed`: one sample of history, no pipeline.

## Test plan
- **Constant input**: `sample_in`=2000 continuously, WINDOW=1024.
  - First pulse at cycle 2048.
  - `peak_max`=`peak_min`=2000, `vpp`=0, `cross_cnt`=0.
- **Square wave**: 0/4000 with a period of 64 samples, continuous valid.
  - `peak_max`=4000, `peak_min`=0, `vpp`=4000.
  - `cross_cnt`=16 on every MEAS pulse.
  - No pulse during CAL.
- **Hysteresis noise rejection**: square wave 1000/3000 plus ±40 LSB noise at each level, HYST=64.
  - `cross_cnt` equals exactly the number of square rising edges in the window.
  - Noise toggling around `thr` ± 40 adds no counts.
- **Gapped valid**: same square wave, with `sample_valid` high one cycle in three.
  - Identical output values.
  - Pulse spacing is 3072 cycles.
  - `meas_valid` stays one cycle wide.
- **Reset mid-MEAS**: assert `rst_n`=0 at sample 500 of a MEAS window.
  - All outputs read 0 immediately.
  - After release, the next pulse comes at 2048 accepted samples.
- **Saturation and boundary crossing**: WINDOW=2^17 with alternating 0/4095 every sample.
  - `cross_cnt`=65535 (saturated).
  - A separate run places a rising crossing on sample WINDOW-1; it is counted in that window and not in the next.
